// File: rtl/alu_op_scheduler_if.sv
// Request/response bundle between two command sources, the scheduler and the
// shared logic unit. The scheduler sits on the slave side.
interface alu_op_scheduler_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req1_valid;
    logic             req0_ready;
    logic             req1_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [4:0]       req0_op;
    logic [4:0]       req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_op, req1_op, alu_result, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_op, req1_op, alu_result, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one combinational logic unit between two
// requesters: IDLE accepts a command, EXEC captures the result, RESP holds it.
module alu_op_scheduler #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_scheduler_if.slave   bus,
    output logic                busy,
    output logic [15:0]         op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             rr_prio;      // requester that wins when both are valid
    logic             grant_valid;
    logic             grant_id;
    logic             accept;
    logic             rsp_fire;
    logic             op_legal;

    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [4:0]       alu_op_q;
    logic             exec_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_err_q;
    logic             rsp_id_q;
    logic [15:0]      op_count_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = rr_prio;
        end else if (bus.req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (bus.req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    assign accept         = (state == IDLE) && grant_valid && !rst;
    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept &&  grant_id;

    assign rsp_fire = (state == RESP) && bus.rsp_ready;
    assign op_legal = (alu_op_q != 5'd0) && (alu_op_q <= 5'd12);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_valid)   state_next = EXEC;
            EXEC:                       state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The alu_* registers double as the command latch: loaded on accept and
    // cleared when EXEC ends, so they read zero outside EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_prio      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 5'd0;
            exec_id_q    <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            op_count_q   <= 16'd0;
        end else begin
            if (accept) begin
                alu_a_q   <= grant_id ? bus.req1_a  : bus.req0_a;
                alu_b_q   <= grant_id ? bus.req1_b  : bus.req0_b;
                alu_op_q  <= grant_id ? bus.req1_op : bus.req0_op;
                exec_id_q <= grant_id;
                rr_prio   <= ~grant_id;
            end else if (state == EXEC) begin
                alu_a_q      <= '0;
                alu_b_q      <= '0;
                alu_op_q     <= 5'd0;
                rsp_result_q <= op_legal ? bus.alu_result : '0;
                rsp_err_q    <= !op_legal;
                rsp_id_q     <= exec_id_q;
            end

            if (rsp_fire) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = (state != IDLE);
    assign op_count       = op_count_q;

    a_ready_exclusive: assert property (@(posedge clk)
        !(bus.req0_ready && bus.req1_ready));

    a_rsp_held: assert property (@(posedge clk) disable iff (rst)
        (state == RESP && !bus.rsp_ready) |=>
        (state == RESP && $stable(rsp_result_q) && $stable(rsp_id_q) && $stable(rsp_err_q)));

endmodule
